alu_slice_sequencer: RTL and testbench

Multi-cycle controller that runs a NIBBLES×4-bit operation through one external combinational alu74181 slice, least-significant nibble first.
- Each cycle it drives one operand nibble and the op code into the ALU.
- It captures F, Cn4 and AeqB from the ALU and ripples the carry through a register.
- It sits both upstream (operand/op driver) and downstream (result/flag collector) of the ALU. It gives the datapath a wide ALU at the cost of a single 4-bit slice.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_slice_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_slice_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the nibble-serial 74181 sequencer.
//   seq_state_t : sequencer state encoding
//   NIBBLE      : width of one 74181 slice
//   S_*         : commonly used 74181 function selects (active-high data)
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int NIBBLE = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   // 74181 select codes, active-high data convention
   localparam logic [3:0] S_ADD    = 4'b1001;  // M=0: A plus B
   localparam logic [3:0] S_SUB    = 4'b0110;  // M=0: A minus B minus 1 (+Cn)
   localparam logic [3:0] S_NOTA   = 4'b0000;  // M=1: not A
   localparam logic [3:0] S_MINUS1 = 4'b0011;  // M=0: minus 1
   localparam logic [3:0] S_ANOTB  = 4'b0111;  // M=1: A and not B

endpackage

// File: rtl/alu_slice_sequencer.sv
// -----------------------------------------------------------------------------
// alu_slice_sequencer
// Runs a NIBBLES x 4-bit operation through one external 74181 slice, least
// significant nibble first, rippling the carry through a register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request, accepted only in IDLE
//   op_a, op_b            W-bit operands (W = 4*NIBBLES)
//   op_s, op_m, op_cin    74181 select, mode (1 = logic), active-high carry in
//   busy, done            RUN indicator, one-cycle completion pulse
//   result, cout          assembled F, active-high carry out (0 in logic mode)
//   zero, eq              result == 0, AND of A=B over all nibbles
//   alu_a/b/s/m/cn        drive to the external 74181 (alu_cn active-low)
//   alu_f/cn4/aeqb        response from the external 74181 (alu_cn4 active-low)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; ALU inputs parked at reset values
// RUN     | one nibble per cycle through the ALU, captured at each edge
// DONE    | done pulse for one cycle, then back to IDLE
// -----------------------------------------------------------------------------
module alu_slice_sequencer
   import alu_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [NIBBLE*NIBBLES-1:0] op_a,
   input  logic [NIBBLE*NIBBLES-1:0] op_b,
   input  logic [3:0]                op_s,
   input  logic                      op_m,
   input  logic                      op_cin,
   output logic                      busy,
   output logic                      done,
   output logic [NIBBLE*NIBBLES-1:0] result,
   output logic                      cout,
   output logic                      zero,
   output logic                      eq,
   output logic [3:0]                alu_a,
   output logic [3:0]                alu_b,
   output logic [3:0]                alu_s,
   output logic                      alu_m,
   output logic                      alu_cn,
   input  logic [3:0]                alu_f,
   input  logic                      alu_cn4,
   input  logic                      alu_aeqb
);

   localparam int W    = NIBBLE * NIBBLES;
   localparam int IDXW = $clog2(NIBBLES);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

   generate
      if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_nibbles
         $error("alu_slice_sequencer: NIBBLES must be in 2..8");
      end
   endgenerate

   seq_state_t      state_q, state_d;

   logic [W-1:0]    a_q, b_q;
   logic [3:0]      s_q;
   logic            m_q;
   logic            carry_n_q;
   logic            eq_acc_q;
   logic [IDXW-1:0] idx_q;

   logic [W-1:0]    result_q;
   logic            cout_q, zero_q, eq_q;

   logic            accept, capture, last;
   logic [W-1:0]    result_ins;

   assign last = (idx_q == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      accept  = 1'b0;
      capture = 1'b0;
      alu_a   = '0;
      alu_b   = '0;
      alu_s   = '0;
      alu_m   = 1'b0;
      alu_cn  = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            busy    = 1'b1;
            capture = 1'b1;
            alu_a   = a_q[NIBBLE*idx_q +: NIBBLE];
            alu_b   = b_q[NIBBLE*idx_q +: NIBBLE];
            alu_s   = s_q;
            alu_m   = m_q;
            alu_cn  = carry_n_q;
            if (last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Result with the current ALU nibble merged in, so zero can be judged on
   // the final edge from the complete word rather than one cycle late.
   always_comb begin
      result_ins = result_q;
      result_ins[NIBBLE*idx_q +: NIBBLE] = alu_f;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         s_q       <= '0;
         m_q       <= 1'b0;
         carry_n_q <= 1'b1;
         eq_acc_q  <= 1'b0;
         idx_q     <= '0;
         result_q  <= '0;
         cout_q    <= 1'b0;
         zero_q    <= 1'b0;
         eq_q      <= 1'b0;
      end else if (accept) begin
         a_q       <= op_a;
         b_q       <= op_b;
         s_q       <= op_s;
         m_q       <= op_m;
         carry_n_q <= ~op_cin;
         eq_acc_q  <= 1'b1;
         idx_q     <= '0;
      end else if (capture) begin
         result_q  <= result_ins;
         carry_n_q <= alu_cn4;
         eq_acc_q  <= eq_acc_q & alu_aeqb;
         idx_q     <= idx_q + IDXW'(1);
         if (last) begin
            // carry chain keeps running in logic mode but is not reported
            cout_q <= ~alu_cn4 & ~m_q;
            zero_q <= (result_ins == '0);
            eq_q   <= eq_acc_q & alu_aeqb;
            idx_q  <= '0;
         end
      end
   end

   assign result = result_q;
   assign cout   = cout_q;
   assign zero   = zero_q;
   assign eq     = eq_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_slice_sequencer
// Bench for alu_slice_sequencer (NIBBLES=4) with a behavioural 74181 slice on
// the alu_* ports and a full-width arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_slice_sequencer;
   import alu_pkg::*;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] op_a = '0, op_b = '0;
   logic [3:0]   op_s = '0;
   logic         op_m = 1'b0, op_cin = 1'b0;

   logic         busy, done, cout, zero, eq;
   logic [W-1:0] result;
   logic [3:0]   alu_a, alu_b, alu_s, alu_f;
   logic         alu_m, alu_cn, alu_cn4, alu_aeqb;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   alu_slice_sequencer #(.NIBBLES(NIB)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
      .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero), .eq(eq),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
      .alu_f(alu_f), .alu_cn4(alu_cn4), .alu_aeqb(alu_aeqb)
   );

   // 74181 slice, active-high data: arithmetic F = X + Y + C, logic F = ~(X ^ Y)
   logic [3:0] sx, sy;
   logic [4:0] ssum;
   always_comb begin
      sx       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
      sy       = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
      ssum     = {1'b0, sx} + {1'b0, sy} + {4'b0, ~alu_cn};
      alu_f    = alu_m ? ~(sx ^ sy) : ssum[3:0];
      alu_cn4  = ~ssum[4];
      alu_aeqb = (alu_f == 4'hF);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Whole-word reference: the bitwise X/Y terms of the 74181 extend across
   // nibbles, so the full operation is one W-bit addition.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] s, input logic m, input logic cin,
                                 output logic [W-1:0] r, output logic co,
                                 output logic z, output logic e);
      logic [W-1:0] x, y;
      logic [W:0]   sum;
      x   = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
      y   = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
      sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
      r   = m ? ~(x ^ y) : sum[W-1:0];
      co  = m ? 1'b0 : sum[W];
      z   = (r == '0);
      e   = (r == {W{1'b1}});
   endfunction

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] s, input logic m, input logic cin);
      logic [W-1:0] er;
      logic eco, ez, ee;
      int n, busy_cnt, m_cnt;
      model(a, b, s, m, cin, er, eco, ez, ee);
      @(negedge clk);
      op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op_a = W'($urandom); op_b = W'($urandom); op_s = 4'($urandom); op_m = ~m; op_cin = ~cin;
      n = 0; busy_cnt = 0; m_cnt = 0;
      while (!done && n < NIB + 6) begin
         if (busy) begin
            busy_cnt++;
            if (alu_m == m) m_cnt++;
         end
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, n, NIB);
      chk({tag, " busy_cycles"}, busy_cnt, NIB);
      chk({tag, " alu_m_cycles"}, m_cnt, NIB);
      chk({tag, " done"}, done, 1'b1);
      chk({tag, " busy_at_done"}, busy, 1'b0);
      chk({tag, " result"}, result, er);
      chk({tag, " cout"}, cout, eco);
      chk({tag, " zero"}, zero, ez);
      chk({tag, " eq"}, eq, ee);
      @(negedge clk);
      chk({tag, " done_one_cycle"}, done, 1'b0);
      chk({tag, " result_hold"}, result, er);
   endtask

   typedef struct {
      logic [W-1:0] a, b;
      logic [3:0]   s;
      logic         m, cin;
   } op_t;

   initial begin
      op_t          ops[6];
      logic [W-1:0] er;
      logic         eco, ez, ee;
      int           dcnt, k, cyc, last_done;

      // reset state
      #2;
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
      chk("rst result", result, '0);
      chk("rst flags", {cout, zero, eq}, 3'b000);
      chk("rst alu_abs", {alu_a, alu_b, alu_s}, 12'h000);
      chk("rst alu_m_cn", {alu_m, alu_cn}, 2'b01);
      @(negedge clk);
      rst_n = 1'b1;

      // directed operations
      run_op("add",      16'h1234, 16'h0FCD, S_ADD,  1'b0, 1'b0);
      run_op("add_rip",  16'hFFFF, 16'h0001, S_ADD,  1'b0, 1'b0);
      run_op("sub",      16'h5000, 16'h1234, S_SUB,  1'b0, 1'b1);
      run_op("sub_eq",   16'h7A7A, 16'h7A7A, S_SUB,  1'b0, 1'b0);
      run_op("not_a",    16'hC3A5, 16'hFFFF, S_NOTA, 1'b1, 1'b1);
      run_op("minus1",   16'h0000, 16'h5555, S_MINUS1, 1'b0, 1'b1);
      run_op("anotb",    16'hF0F0, 16'h3C3C, S_ANOTB,  1'b1, 1'b0);
      chk("idle alu_cn", alu_cn, 1'b1);

      // start during RUN is ignored
      model(16'h0102, 16'h0304, S_ADD, 1'b0, 1'b1, er, eco, ez, ee);
      @(negedge clk);
      op_a = 16'h0102; op_b = 16'h0304; op_s = S_ADD; op_m = 1'b0; op_cin = 1'b1; start = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         start = (i == 1);
         if (i == 0) begin
            op_a = 16'hFFFF; op_b = 16'hFFFF;
         end
         if (done) begin
            dcnt++;
            chk("ign_start result", result, er);
         end
      end
      chk("ign_start done_count", dcnt, 1);

      // reset during the second RUN cycle
      @(negedge clk);
      op_a = 16'h1111; op_b = 16'h2222; op_s = S_ADD; op_m = 1'b0; op_cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort busy", busy, 1'b0);
      chk("abort result", result, '0);
      chk("abort done", done, 1'b0);
      chk("abort alu_cn", alu_cn, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      chk("abort no_activity", dcnt, 0);
      run_op("after_abort", 16'hABCD, 16'h1111, S_ADD, 1'b0, 1'b1);

      // back-to-back with start held high
      ops[0] = '{16'hFFFF, 16'h0001, S_ADD,  1'b0, 1'b0};
      ops[1] = '{16'h0010, 16'h0020, S_ADD,  1'b0, 1'b0};
      ops[2] = '{16'h0000, 16'h0001, S_SUB,  1'b0, 1'b0};
      ops[3] = '{16'h2345, 16'h1111, S_ADD,  1'b0, 1'b0};
      ops[4] = '{16'h00FF, 16'h0000, S_NOTA, 1'b1, 1'b0};
      ops[5] = '{16'h4444, 16'h4444, S_SUB,  1'b0, 1'b1};
      @(negedge clk);
      op_a = ops[0].a; op_b = ops[0].b; op_s = ops[0].s; op_m = ops[0].m; op_cin = ops[0].cin;
      start = 1'b1;
      k = 0; cyc = 0; last_done = 0;
      while (k < 6 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            model(ops[k].a, ops[k].b, ops[k].s, ops[k].m, ops[k].cin, er, eco, ez, ee);
            chk($sformatf("b2b%0d result", k), result, er);
            chk($sformatf("b2b%0d cout", k), cout, eco);
            chk($sformatf("b2b%0d zero", k), zero, ez);
            if (k > 0) chk($sformatf("b2b%0d period", k), cyc - last_done, 6);
            last_done = cyc;
            k++;
            if (k < 6) begin
               op_a = ops[k].a; op_b = ops[k].b; op_s = ops[k].s;
               op_m = ops[k].m; op_cin = ops[k].cin;
            end
         end
      end
      start = 1'b0;
      chk("b2b completed", k, 6);
      repeat (8) @(negedge clk);

      // randomized operations
      for (int i = 0; i < 24; i++) begin
         run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
